multi_missile_square_object: RTL and testbench

//  N-channel successor of the single missile bracket object. Tracks up to N_MISSILES

---
 rtl/multi_missile_square_object_pkg.sv | 14 +
 rtl/multi_missile_square_object_if.sv | 32 +++
 rtl/multi_missile_square_object_rotator.sv | 24 ++
 rtl/multi_missile_square_object.sv | 129 ++++++++++++
 tb/tb_multi_missile_square_object.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/multi_missile_square_object_pkg.sv
// missile_pkg: shared direction encoding, colour key and coordinate width for the missile objects
package missile_pkg;
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;
    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;
    localparam int COORD_W = 11;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/multi_missile_square_object_if.sv
// multi_missile_square_object_if: pixel/missile-state bundle between game logic, VGA mux and the missile object
//   master: drives pixel position, frame pulse and per-channel missile state; receives draw results
//   slave : the missile object itself
interface multi_missile_square_object_if
    import missile_pkg::*;
#(
    parameter int N_MISSILES = 4,
    parameter int IDX_W      = idx_w(N_MISSILES)
);
    logic [COORD_W-1:0]            pixelX;
    logic [COORD_W-1:0]            pixelY;
    logic                          startOfFrame;
    logic [N_MISSILES*COORD_W-1:0] topLeftX;
    logic [N_MISSILES*COORD_W-1:0] topLeftY;
    logic [2*N_MISSILES-1:0]       dir;
    logic [N_MISSILES-1:0]         active;
    logic [COORD_W-1:0]            offsetX;
    logic [COORD_W-1:0]            offsetY;
    logic                          drawingRequest;
    logic [7:0]                    RGBout;
    logic [IDX_W-1:0]              hitIndex;
    logic [IDX_W:0]                hitCount;

    modport master (
        output pixelX, pixelY, startOfFrame, topLeftX, topLeftY, dir, active,
        input  offsetX, offsetY, drawingRequest, RGBout, hitIndex, hitCount
    );
    modport slave (
        input  pixelX, pixelY, startOfFrame, topLeftX, topLeftY, dir, active,
        output offsetX, offsetY, drawingRequest, RGBout, hitIndex, hitCount
    );
endinterface

// File: rtl/multi_missile_square_object_rotator.sv
// missile_offset_rotator: maps a missile-relative (dx,dy) to native bitmap (column,row) for the given direction
//   dx, dy       : pixel offset from the missile's top-left corner on screen
//   dir          : missile direction
//   off_x, off_y : bitmap column/row in the native (DIR_RIGHT) W x H bitmap
module missile_offset_rotator
    import missile_pkg::*;
#(
    parameter int W = 8,
    parameter int H = 4
) (
    input  logic [COORD_W-1:0] dx,
    input  logic [COORD_W-1:0] dy,
    input  dir_t               dir,
    output logic [COORD_W-1:0] off_x,
    output logic [COORD_W-1:0] off_y
);
    localparam logic [COORD_W-1:0] WM = COORD_W'(W - 1);
    localparam logic [COORD_W-1:0] HM = COORD_W'(H - 1);

    always_comb begin
        off_x = dir == DIR_UP ? WM - dy : dir == DIR_DOWN ? dy : dir == DIR_LEFT ? WM - dx : dx;
        off_y = dir == DIR_UP ? dx : dir == DIR_DOWN ? HM - dx : dir == DIR_LEFT ? HM - dy : dy;
    end
endmodule

// File: rtl/multi_missile_square_object.sv
// multi_missile_square_object: N-channel missile hit test with per-frame shadow state and 2-cycle pixel pipeline
//   clk    : system clock
//   resetN : async active-low reset
//   bus    : slave side of multi_missile_square_object_if (pixel, frame pulse, missile state in; draw results out)
module multi_missile_square_object
    import missile_pkg::*;
#(
    parameter int         N_MISSILES      = 4,
    parameter int         OBJECT_WIDTH_X  = 8,
    parameter int         OBJECT_HEIGHT_Y = 4,
    parameter logic [7:0] OBJECT_COLOR    = 8'h5b,
    parameter int         IDX_W           = idx_w(N_MISSILES)
) (
    input logic                          clk,
    input logic                          resetN,
    multi_missile_square_object_if.slave bus
);
    localparam logic [COORD_W:0] W12 = (COORD_W + 1)'(OBJECT_WIDTH_X);
    localparam logic [COORD_W:0] H12 = (COORD_W + 1)'(OBJECT_HEIGHT_Y);

    logic [N_MISSILES*COORD_W-1:0] sh_x, sh_y;
    logic [2*N_MISSILES-1:0]       sh_dir;
    logic [N_MISSILES-1:0]         sh_act;
    logic                          hit [N_MISSILES];
    logic                          s1_in [N_MISSILES];
    logic [COORD_W-1:0]            s1_dx [N_MISSILES];
    logic [COORD_W-1:0]            s1_dy [N_MISSILES];
    dir_t                          s1_dir [N_MISSILES];
    logic [COORD_W-1:0]            sel_dx, sel_dy, rot_x, rot_y;
    dir_t                          sel_dir;
    logic [IDX_W-1:0]              sel_idx;
    logic [IDX_W:0]                cnt;
    logic                          any;

    // Shadow copy taken only on the frame pulse so a frame never tears
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sh_x   <= '0;
            sh_y   <= '0;
            sh_dir <= '0;
            sh_act <= '0;
        end else if (bus.startOfFrame) begin
            sh_x   <= bus.topLeftX;
            sh_y   <= bus.topLeftY;
            sh_dir <= bus.dir;
            sh_act <= bus.active;
        end
    end

    // Edges are 12 bits wide so a box hanging past 2047 clips instead of wrapping to 0.
    // dir bit0 set means RIGHT/LEFT, i.e. native footprint; UP/DOWN swap W and H.
    for (genvar i = 0; i < N_MISSILES; i++) begin : g_ch
        logic [COORD_W:0] x0, y0, px, py, fw, fh;
        assign x0     = {1'b0, sh_x[i*COORD_W +: COORD_W]};
        assign y0     = {1'b0, sh_y[i*COORD_W +: COORD_W]};
        assign px     = {1'b0, bus.pixelX};
        assign py     = {1'b0, bus.pixelY};
        assign fw     = sh_dir[2*i] ? W12 : H12;
        assign fh     = sh_dir[2*i] ? H12 : W12;
        assign hit[i] = sh_act[i] && px >= x0 && px < x0 + fw && py >= y0 && py < y0 + fh;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < N_MISSILES; i++) begin
                s1_in[i]  <= 1'b0;
                s1_dx[i]  <= '0;
                s1_dy[i]  <= '0;
                s1_dir[i] <= DIR_UP;
            end
        end else begin
            for (int i = 0; i < N_MISSILES; i++) begin
                s1_in[i]  <= hit[i];
                s1_dx[i]  <= bus.pixelX - sh_x[i*COORD_W +: COORD_W];
                s1_dy[i]  <= bus.pixelY - sh_y[i*COORD_W +: COORD_W];
                s1_dir[i] <= dir_t'(sh_dir[2*i +: 2]);
            end
        end
    end

    // Scan from the top channel down so the lowest hitting index is the last to win
    always_comb begin
        sel_dx  = '0;
        sel_dy  = '0;
        sel_dir = DIR_RIGHT;
        sel_idx = '0;
        any     = 1'b0;
        cnt     = '0;
        for (int i = N_MISSILES - 1; i >= 0; i--) begin
            cnt = cnt + {{IDX_W{1'b0}}, s1_in[i]};
            if (s1_in[i]) begin
                sel_dx  = s1_dx[i];
                sel_dy  = s1_dy[i];
                sel_dir = s1_dir[i];
                sel_idx = IDX_W'(i);
                any     = 1'b1;
            end
        end
    end

    missile_offset_rotator #(
        .W(OBJECT_WIDTH_X),
        .H(OBJECT_HEIGHT_Y)
    ) u_rot (
        .dx   (sel_dx),
        .dy   (sel_dy),
        .dir  (sel_dir),
        .off_x(rot_x),
        .off_y(rot_y)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.drawingRequest <= 1'b0;
            bus.RGBout         <= TRANSPARENT_ENCODING;
            bus.offsetX        <= '0;
            bus.offsetY        <= '0;
            bus.hitIndex       <= '0;
            bus.hitCount       <= '0;
        end else begin
            bus.drawingRequest <= any;
            bus.RGBout         <= any ? OBJECT_COLOR : TRANSPARENT_ENCODING;
            bus.offsetX        <= any ? rot_x : '0;
            bus.offsetY        <= any ? rot_y : '0;
            bus.hitIndex       <= sel_idx;
            bus.hitCount       <= cnt;
        end
    end
endmodule

// File: tb/tb_multi_missile_square_object.sv
// tb_multi_missile_square_object: directed self-checking bench for multi_missile_square_object (N=4, 8x4 bitmap)
module tb_multi_missile_square_object;
    import missile_pkg::*;

    localparam logic [35:0] MISS = {1'b0, 8'hFF, 27'd0};

    logic clk;
    logic resetN;
    int   checks;
    int   failures;

    multi_missile_square_object_if #(.N_MISSILES(4)) bus ();

    multi_missile_square_object #(.N_MISSILES(4)) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {drawingRequest, RGBout, offsetX, offsetY, hitIndex, hitCount}
    function automatic logic [35:0] obs();
        return {bus.drawingRequest, bus.RGBout, bus.offsetX, bus.offsetY, bus.hitIndex, bus.hitCount};
    endfunction

    function automatic logic [35:0] hitv(input int ox, input int oy, input int idx, input int cnt);
        return {1'b1, 8'h5b, 11'(ox), 11'(oy), 2'(idx), 3'(cnt)};
    endfunction

    task automatic set_ch(input int i, input int x, input int y, input dir_t d, input logic a);
        bus.topLeftX[i*11 +: 11] = 11'(x);
        bus.topLeftY[i*11 +: 11] = 11'(y);
        bus.dir[i*2 +: 2]        = d;
        bus.active[i]            = a;
    endtask

    task automatic sof();
        bus.startOfFrame = 1'b1;
        @(posedge clk);
        #1 bus.startOfFrame = 1'b0;
    endtask

    task automatic run_pix(input int x, input int y);
        bus.pixelX = 11'(x);
        bus.pixelY = 11'(y);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        bus.pixelX = '0;
        bus.pixelY = '0;
        bus.startOfFrame = 1'b0;
        bus.topLeftX = '0;
        bus.topLeftY = '0;
        bus.dir = '0;
        bus.active = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== MISS) begin failures++; $display("FAIL reset got=%h exp=%h", obs(), MISS); end
        resetN = 1'b1;
        run_pix(0, 0);
        checks++;
        if (obs() !== MISS) begin failures++; $display("FAIL reset_idle got=%h exp=%h", obs(), MISS); end
    endtask

    task automatic test_basic();
        set_ch(0, 100, 50, DIR_RIGHT, 1'b1);
        sof();
        bus.pixelX = 11'd100;
        bus.pixelY = 11'd50;
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== MISS) begin failures++; $display("FAIL latency_1clk got=%h exp=%h", obs(), MISS); end
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== hitv(0, 0, 0, 1)) begin failures++; $display("FAIL basic_hit got=%h exp=%h", obs(), hitv(0, 0, 0, 1)); end
        run_pix(108, 50);
        checks++;
        if (obs() !== MISS) begin failures++; $display("FAIL basic_right_edge got=%h exp=%h", obs(), MISS); end
        run_pix(107, 53);
        checks++;
        if (obs() !== hitv(7, 3, 0, 1)) begin failures++; $display("FAIL basic_corner got=%h exp=%h", obs(), hitv(7, 3, 0, 1)); end
        run_pix(100, 54);
        checks++;
        if (obs() !== MISS) begin failures++; $display("FAIL basic_bottom_edge got=%h exp=%h", obs(), MISS); end
    endtask

    task automatic test_rotate();
        set_ch(0, 100, 50, DIR_UP, 1'b1);
        sof();
        run_pix(101, 55);
        checks++;
        if (obs() !== hitv(2, 1, 0, 1)) begin failures++; $display("FAIL up_hit got=%h exp=%h", obs(), hitv(2, 1, 0, 1)); end
        run_pix(104, 50);
        checks++;
        if (obs() !== MISS) begin failures++; $display("FAIL up_width got=%h exp=%h", obs(), MISS); end
        run_pix(100, 57);
        checks++;
        if (obs() !== hitv(0, 0, 0, 1)) begin failures++; $display("FAIL up_bottom got=%h exp=%h", obs(), hitv(0, 0, 0, 1)); end
        set_ch(0, 100, 50, DIR_DOWN, 1'b1);
        sof();
        run_pix(101, 55);
        checks++;
        if (obs() !== hitv(5, 2, 0, 1)) begin failures++; $display("FAIL down_hit got=%h exp=%h", obs(), hitv(5, 2, 0, 1)); end
        set_ch(0, 100, 50, DIR_LEFT, 1'b1);
        sof();
        run_pix(101, 51);
        checks++;
        if (obs() !== hitv(6, 2, 0, 1)) begin failures++; $display("FAIL left_hit got=%h exp=%h", obs(), hitv(6, 2, 0, 1)); end
    endtask

    task automatic test_overlap();
        set_ch(0, 100, 50, DIR_RIGHT, 1'b0);
        set_ch(1, 200, 200, DIR_RIGHT, 1'b1);
        set_ch(3, 200, 200, DIR_RIGHT, 1'b1);
        sof();
        run_pix(202, 201);
        checks++;
        if (obs() !== hitv(2, 1, 1, 2)) begin failures++; $display("FAIL overlap_two got=%h exp=%h", obs(), hitv(2, 1, 1, 2)); end
        set_ch(1, 200, 200, DIR_RIGHT, 1'b0);
        sof();
        run_pix(202, 201);
        checks++;
        if (obs() !== hitv(2, 1, 3, 1)) begin failures++; $display("FAIL overlap_one got=%h exp=%h", obs(), hitv(2, 1, 3, 1)); end
        set_ch(3, 200, 200, DIR_RIGHT, 1'b0);
    endtask

    task automatic test_no_tear();
        set_ch(0, 100, 50, DIR_RIGHT, 1'b1);
        sof();
        set_ch(0, 300, 50, DIR_RIGHT, 1'b1);
        run_pix(100, 50);
        checks++;
        if (obs() !== hitv(0, 0, 0, 1)) begin failures++; $display("FAIL tear_old_pos got=%h exp=%h", obs(), hitv(0, 0, 0, 1)); end
        run_pix(300, 50);
        checks++;
        if (obs() !== MISS) begin failures++; $display("FAIL tear_new_pos got=%h exp=%h", obs(), MISS); end
        bus.pixelX = 11'd300;
        bus.pixelY = 11'd50;
        bus.startOfFrame = 1'b1;
        @(posedge clk);
        #1 bus.startOfFrame = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== MISS) begin failures++; $display("FAIL sof_same_cycle got=%h exp=%h", obs(), MISS); end
        run_pix(300, 50);
        checks++;
        if (obs() !== hitv(0, 0, 0, 1)) begin failures++; $display("FAIL sof_after got=%h exp=%h", obs(), hitv(0, 0, 0, 1)); end
        set_ch(0, 300, 50, DIR_RIGHT, 1'b0);
    endtask

    task automatic test_edge();
        set_ch(2, 2044, 10, DIR_RIGHT, 1'b1);
        sof();
        run_pix(2046, 10);
        checks++;
        if (obs() !== hitv(2, 0, 2, 1)) begin failures++; $display("FAIL edge_hit got=%h exp=%h", obs(), hitv(2, 0, 2, 1)); end
        run_pix(0, 10);
        checks++;
        if (obs() !== MISS) begin failures++; $display("FAIL edge_no_wrap got=%h exp=%h", obs(), MISS); end
        run_pix(2047, 13);
        checks++;
        if (obs() !== hitv(3, 3, 2, 1)) begin failures++; $display("FAIL edge_last got=%h exp=%h", obs(), hitv(3, 3, 2, 1)); end
    endtask

    task automatic test_back_to_back();
        bus.pixelX = 11'd2045;
        bus.pixelY = 11'd11;
        @(posedge clk);
        #1;
        bus.pixelX = 11'd1;
        bus.pixelY = 11'd11;
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== hitv(1, 1, 2, 1)) begin failures++; $display("FAIL b2b_first got=%h exp=%h", obs(), hitv(1, 1, 2, 1)); end
        bus.pixelX = 11'd2047;
        bus.pixelY = 11'd12;
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== MISS) begin failures++; $display("FAIL b2b_second got=%h exp=%h", obs(), MISS); end
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== hitv(3, 2, 2, 1)) begin failures++; $display("FAIL b2b_third got=%h exp=%h", obs(), hitv(3, 2, 2, 1)); end
    endtask

    task automatic test_async_reset();
        run_pix(2046, 10);
        checks++;
        if (obs() !== hitv(2, 0, 2, 1)) begin failures++; $display("FAIL areset_pre got=%h exp=%h", obs(), hitv(2, 0, 2, 1)); end
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (obs() !== MISS) begin failures++; $display("FAIL areset_immediate got=%h exp=%h", obs(), MISS); end
        @(posedge clk);
        #1 resetN = 1'b1;
        run_pix(2046, 10);
        checks++;
        if (obs() !== MISS) begin failures++; $display("FAIL areset_cleared got=%h exp=%h", obs(), MISS); end
        sof();
        run_pix(2046, 10);
        checks++;
        if (obs() !== hitv(2, 0, 2, 1)) begin failures++; $display("FAIL areset_reload got=%h exp=%h", obs(), hitv(2, 0, 2, 1)); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_rotate();
        test_overlap();
        test_no_tear();
        test_edge();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
